mul_div_unit: RTL and testbench
===============================

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 SHALL have parameter: W, 32, operand/result width; even, >=8.
REQ-002 SHALL have ports (clock and reset first):
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- op  in  4  operation: 0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MADD, 6 MADDU, 7 MSUB, 8 MSUBU; 9-15 NOP.
- start  in  1  request valid.
- flush  in  1  cancel in-flight operation.
- opr1  in  W  multiplicand / dividend.
- opr2  in  W  multiplier / divisor.
- hi_i  in  W  current HI, accumulate source.
- lo_i  in  W  current LO, accumulate source.
- busy  out  1  operation in flight.
- done  out  1  one-cycle result-valid pulse.
- hi_o  out  W  HI result (remainder for divide).
- lo_o  out  W  LO result (quotient for divide).

Function
REQ-003 SHALL implement FSM states IDLE, MUL1, MUL2, DIV; busy=1 in every state except IDLE.
REQ-004 SHALL accept a request at cycle T iff state=IDLE, start=1, flush=0 and op is non-NOP; opr1, opr2, hi_i and lo_i are sampled at T.
REQ-005 SHALL ignore start while busy=1, and ignore start with a NOP op.
REQ-006 Multiply: MUL1 SHALL register four half-width partial products of the operands (magnitudes for signed ops); MUL2 SHALL sum them and apply the sign.
REQ-007 Multiply SHALL assert done and update hi_o/lo_o at T+2, returning to IDLE in the same edge.
REQ-008 Signed multiply SHALL take product sign = opr1[W-1] XOR opr2[W-1]; unsigned ops SHALL use raw operands.
REQ-009 MADD/MADDU SHALL produce {hi_i,lo_i}+product; MSUB/MSUBU SHALL produce {hi_i,lo_i}-product; both modulo 2^(2W), no overflow flag.
REQ-010 Divide SHALL be radix-2 restoring over magnitudes, one quotient bit per cycle, W iterations tracked by a counter; done and results SHALL appear at T+W+1.
REQ-011 Signed divide: quotient negative iff operand signs differ; remainder takes dividend sign.
REQ-012 Divisor zero SHALL NOT stall: lo_o=all ones, hi_o=opr1, same latency T+W+1.
REQ-013 hi_o/lo_o SHALL hold their last value until the next done.
REQ-014 flush=1 in any busy state SHALL return the FSM to IDLE at the next edge, with no done and no hi_o/lo_o update.
REQ-015 flush and start in the same IDLE cycle: start SHALL be ignored.
REQ-016 A new request SHALL be acceptable in the cycle following done or following a flush.

Reset
REQ-017 rst=1 SHALL immediately force: state IDLE, busy 0, done 0, hi_o 0, lo_o 0, iteration counter 0, all internal registers 0.
REQ-018 rst asserted mid-operation SHALL abort the operation with no done.

Configuration
REQ-019 With MDU_MACC_EN defined, ops 5-8 SHALL be supported per REQ-009.
REQ-020 Without MDU_MACC_EN, ops 5-8 SHALL be treated as NOP (not accepted, busy stays 0, no done), and hi_i/lo_i SHALL be unused.

Verification (W=32)
REQ-021 MULT opr1=FFFFFFFF, opr2=00000002 -> done at T+2, hi_o=FFFFFFFF, lo_o=FFFFFFFE; MULTU with the same operands -> hi_o=00000001, lo_o=FFFFFFFE.
REQ-022 DIV opr1=FFFFFFF9 (-7), opr2=00000002 -> done at T+33, lo_o=FFFFFFFD, hi_o=FFFFFFFF.
REQ-023 DIVU opr1=00000064, opr2=0 -> done at T+33, lo_o=FFFFFFFF, hi_o=00000064.
REQ-024 DIV started at T, flush=1 at T+5 -> busy=0 at T+6, no done, hi_o/lo_o unchanged; MULTU 3*4 with start at T+6 -> lo_o=0000000C at T+8.
REQ-025 MADDU hi_i=0, lo_i=FFFFFFFF, opr1=opr2=1 -> hi_o=00000001, lo_o=00000000 at T+2 with MDU_MACC_EN; without the macro -> busy stays 0, no done.
REQ-026 rst pulsed at T+10 of a DIV -> busy=0, done=0, hi_o=lo_o=0 immediately; no done follows.

Source files
------------

// File: rtl/mul_div_unit.sv
// Multi-cycle multiply / divide unit: two-stage half-width multiplier and radix-2 restoring divider.
// Optional multiply-accumulate ops (MADD/MADDU/MSUB/MSUBU) are enabled by defining MDU_MACC_EN.
module mul_div_unit #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   op,
  input  logic         start,
  input  logic         flush,
  input  logic [W-1:0] opr1,
  input  logic [W-1:0] opr2,
  input  logic [W-1:0] hi_i,
  input  logic [W-1:0] lo_i,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] hi_o,
  output logic [W-1:0] lo_o
);

  localparam int unsigned HW = W / 2;
  localparam int unsigned DW = 2 * W;
  localparam int unsigned CW = $clog2(W + 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
`ifdef MDU_MACC_EN
  localparam logic [3:0] OP_MADD  = 4'd5;
  localparam logic [3:0] OP_MADDU = 4'd6;
  localparam logic [3:0] OP_MSUB  = 4'd7;
  localparam logic [3:0] OP_MSUBU = 4'd8;
`endif

  typedef enum logic [1:0] {IDLE, MUL1, MUL2, DIV} state_t;

  state_t         state;
  logic [CW-1:0]  cnt;
  logic [W-1:0]   opa;       // multiplicand magnitude, or dividend/quotient shift register
  logic [W-1:0]   opb;       // multiplier / divisor magnitude
  logic [W-1:0]   rem;
  logic [W-1:0]   dvd_raw;
  logic           neg_p;     // product or quotient sign
  logic           neg_r;     // remainder sign
  logic [W-1:0]   pp_ll, pp_lh, pp_hl, pp_hh;

  logic           mul_op_c, div_op_c, sgn_op_c, accept_c;
  logic           neg1_c, neg2_c;
  logic [W-1:0]   mag1_c, mag2_c;
  logic [W:0]     shifted_c, diff_c;
  logic [DW-1:0]  prod_mag_c, prod_c, res_c;

`ifdef MDU_MACC_EN
  logic           macc_op_c, sub_op_c;
  logic           macc, sub;
  logic [DW-1:0]  acc;
`else
  logic           unused_acc;
  assign unused_acc = ^{hi_i, lo_i};
`endif

  // Operation decode
  always_comb begin
    mul_op_c = 1'b0;
    div_op_c = 1'b0;
    sgn_op_c = 1'b0;
`ifdef MDU_MACC_EN
    macc_op_c = 1'b0;
    sub_op_c  = 1'b0;
`endif
    case (op)
      OP_MULT:  begin mul_op_c = 1'b1; sgn_op_c = 1'b1; end
      OP_MULTU: mul_op_c = 1'b1;
      OP_DIV:   begin div_op_c = 1'b1; sgn_op_c = 1'b1; end
      OP_DIVU:  div_op_c = 1'b1;
`ifdef MDU_MACC_EN
      OP_MADD:  begin mul_op_c = 1'b1; sgn_op_c = 1'b1; macc_op_c = 1'b1; end
      OP_MADDU: begin mul_op_c = 1'b1; macc_op_c = 1'b1; end
      OP_MSUB:  begin mul_op_c = 1'b1; sgn_op_c = 1'b1; macc_op_c = 1'b1; sub_op_c = 1'b1; end
      OP_MSUBU: begin mul_op_c = 1'b1; macc_op_c = 1'b1; sub_op_c = 1'b1; end
`endif
      default: ;
    endcase
  end

  assign accept_c = (state == IDLE) && start && !flush && (mul_op_c || div_op_c);

  assign neg1_c = sgn_op_c & opr1[W-1];
  assign neg2_c = sgn_op_c & opr2[W-1];
  assign mag1_c = neg1_c ? -opr1 : opr1;
  assign mag2_c = neg2_c ? -opr2 : opr2;

  // One restoring-division step
  assign shifted_c = {rem, opa[W-1]};
  assign diff_c    = shifted_c - {1'b0, opb};

  // Partial-product summation, sign and optional accumulate
  assign prod_mag_c = {pp_hh, pp_ll} + (DW'(pp_lh) << HW) + (DW'(pp_hl) << HW);
  assign prod_c     = neg_p ? -prod_mag_c : prod_mag_c;

  always_comb begin
    res_c = prod_c;
`ifdef MDU_MACC_EN
    if (macc) res_c = sub ? (acc - prod_c) : (acc + prod_c);
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      hi_o    <= '0;
      lo_o    <= '0;
      cnt     <= '0;
      opa     <= '0;
      opb     <= '0;
      rem     <= '0;
      dvd_raw <= '0;
      neg_p   <= 1'b0;
      neg_r   <= 1'b0;
      pp_ll   <= '0;
      pp_lh   <= '0;
      pp_hl   <= '0;
      pp_hh   <= '0;
`ifdef MDU_MACC_EN
      macc    <= 1'b0;
      sub     <= 1'b0;
      acc     <= '0;
`endif
    end else begin
      done <= 1'b0;
      if (flush && state != IDLE) begin
        state <= IDLE;
        busy  <= 1'b0;
        cnt   <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (accept_c) begin
              busy    <= 1'b1;
              opa     <= mag1_c;
              opb     <= mag2_c;
              dvd_raw <= opr1;
              rem     <= '0;
              cnt     <= '0;
              neg_p   <= neg1_c ^ neg2_c;
              neg_r   <= neg1_c;
`ifdef MDU_MACC_EN
              macc    <= macc_op_c;
              sub     <= sub_op_c;
              acc     <= {hi_i, lo_i};
`endif
              state   <= mul_op_c ? MUL1 : DIV;
            end
          end
          MUL1: begin
            pp_ll <= W'(opa[HW-1:0]) * W'(opb[HW-1:0]);
            pp_lh <= W'(opa[HW-1:0]) * W'(opb[W-1:HW]);
            pp_hl <= W'(opa[W-1:HW]) * W'(opb[HW-1:0]);
            pp_hh <= W'(opa[W-1:HW]) * W'(opb[W-1:HW]);
            state <= MUL2;
          end
          MUL2: begin
            hi_o  <= res_c[DW-1:W];
            lo_o  <= res_c[W-1:0];
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
          DIV: begin
            if (cnt != CW'(W)) begin
              if (!diff_c[W]) begin
                rem <= diff_c[W-1:0];
                opa <= {opa[W-2:0], 1'b1};
              end else begin
                rem <= shifted_c[W-1:0];
                opa <= {opa[W-2:0], 1'b0};
              end
              cnt <= cnt + CW'(1);
            end else begin
              // A zero divisor finishes on schedule with fixed results
              if (opb == '0) begin
                lo_o <= '1;
                hi_o <= dvd_raw;
              end else begin
                lo_o <= neg_p ? -opa : opa;
                hi_o <= neg_r ? -rem : rem;
              end
              cnt   <= '0;
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed corner cases plus randomized ops
// compared against an arithmetic reference model.
module tb_mul_div_unit;
  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   op;
  logic         start, flush;
  logic [W-1:0] opr1, opr2, hi_i, lo_i;
  logic         busy, done;
  logic [W-1:0] hi_o, lo_o;

  int vectors = 0;
  int errors  = 0;
  logic [63:0] last_res = '0;

  mul_div_unit #(.W(W)) dut (
    .clk(clk), .rst(rst), .op(op), .start(start), .flush(flush),
    .opr1(opr1), .opr2(opr2), .hi_i(hi_i), .lo_i(lo_i),
    .busy(busy), .done(done), .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit valid_op(input logic [3:0] o);
`ifdef MDU_MACC_EN
    return (o >= 4'd1) && (o <= 4'd8);
`else
    return (o >= 4'd1) && (o <= 4'd4);
`endif
  endfunction

  // Reference: {hi, lo} computed with plain 64-bit arithmetic
  function automatic logic [63:0] model(input logic [3:0] o, input logic [31:0] a, b, h, l);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    logic [63:0] ps = 64'(sa * sb);
    logic [63:0] pu = 64'(a) * 64'(b);
    logic [63:0] hl = {h, l};
    longint q, r;
    case (o)
      4'd1: return ps;
      4'd2: return pu;
      4'd3: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {32'(r), 32'(q)};
      end
      4'd4: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      4'd5: return hl + ps;
      4'd6: return hl + pu;
      4'd7: return hl - ps;
      4'd8: return hl - pu;
      default: return 64'h0;
    endcase
  endfunction

  task automatic do_op(input logic [3:0] o, input logic [31:0] a, b, h, l, input string tag);
    bit v = valid_op(o);
    int lat = (o == 4'd3 || o == 4'd4) ? int'(W) + 1 : 2;
    logic [63:0] exp = v ? model(o, a, b, h, l) : last_res;
    int k = 0;
    bit seen = 1'b0;
    @(negedge clk);
    op = o; start = 1'b1; opr1 = a; opr2 = b; hi_i = h; lo_i = l;
    @(posedge clk); #1;
    check({tag, " busy_after_start"}, 64'(busy), 64'(v));
    @(negedge clk);
    start = 1'b0; opr1 = $urandom; opr2 = $urandom; hi_i = $urandom; lo_i = $urandom;
    if (v) begin
      while (!seen && k < int'(W) + 8) begin
        @(posedge clk); #1;
        k++;
        if (done) seen = 1'b1;
      end
      check({tag, " latency"}, 64'(k), 64'(lat));
      check({tag, " result"}, {hi_o, lo_o}, exp);
      @(posedge clk); #1;
      check({tag, " idle_after_done"}, {62'h0, busy, done}, 64'h0);
      last_res = exp;
    end else begin
      repeat (3) begin
        @(posedge clk); #1;
        check({tag, " nop_quiet"}, {62'h0, busy, done}, 64'h0);
      end
      check({tag, " nop_hold"}, {hi_o, lo_o}, last_res);
    end
  endtask

  initial begin
    logic [3:0]  o;
    logic [31:0] a, b;
    bit seen;

    rst = 1'b1; op = '0; start = 1'b0; flush = 1'b0;
    opr1 = '0; opr2 = '0; hi_i = '0; lo_i = '0;
    #1;
    check("reset_outputs", {62'h0, busy, done}, 64'h0);
    check("reset_result", {hi_o, lo_o}, 64'h0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    do_op(4'd1, 32'hFFFF_FFFF, 32'h2, 32'h0, 32'h0, "mult_m1x2");
    check("mult_m1x2_const", {hi_o, lo_o}, 64'hFFFF_FFFF_FFFF_FFFE);
    do_op(4'd2, 32'hFFFF_FFFF, 32'h2, 32'h0, 32'h0, "multu_ffx2");
    check("multu_ffx2_const", {hi_o, lo_o}, 64'h0000_0001_FFFF_FFFE);
    do_op(4'd3, 32'hFFFF_FFF9, 32'h2, 32'h0, 32'h0, "div_m7_2");
    check("div_m7_2_const", {hi_o, lo_o}, 64'hFFFF_FFFF_FFFF_FFFD);
    do_op(4'd4, 32'h64, 32'h0, 32'h0, 32'h0, "divu_by0");
    check("divu_by0_const", {hi_o, lo_o}, 64'h0000_0064_FFFF_FFFF);
    do_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h0, "div_minint_m1");
    do_op(4'd6, 32'h1, 32'h1, 32'h0, 32'hFFFF_FFFF, "maddu_carry");
    do_op(4'd7, 32'h3, 32'hFFFF_FFFE, 32'h0, 32'h5, "msub");
    do_op(4'd0, 32'h5, 32'h6, 32'h0, 32'h0, "nop0");
    do_op(4'd12, 32'h5, 32'h6, 32'h0, 32'h0, "nop12");

    // start held during a multiply must not launch a second op
    @(negedge clk); op = 4'd2; start = 1'b1; opr1 = 32'd3; opr2 = 32'd4;
    @(posedge clk); #1;
    @(negedge clk); op = 4'd4; opr1 = 32'd100; opr2 = 32'd7;
    @(posedge clk); #1;
    check("busy_start_mid", {62'h0, busy, done}, 64'h2);
    @(negedge clk); start = 1'b0;
    @(posedge clk); #1;
    check("busy_start_done", 64'(done), 64'h1);
    check("busy_start_result", {hi_o, lo_o}, 64'hC);
    @(posedge clk); #1;
    check("busy_start_no_second", {62'h0, busy, done}, 64'h0);
    last_res = 64'hC;

    // flush and start together in IDLE: nothing accepted
    @(negedge clk); op = 4'd1; start = 1'b1; flush = 1'b1; opr1 = 32'd9; opr2 = 32'd9;
    @(posedge clk); #1;
    check("flush_start_idle_busy", 64'(busy), 64'h0);
    @(negedge clk); start = 1'b0; flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("flush_start_idle_hold", {hi_o, lo_o, 63'h0, done}, {last_res, 64'h0});

    // flush of a DIV after 5 edges, then immediate MULTU
    do_op(4'd2, 32'd5, 32'd7, 32'h0, 32'h0, "pre_flush");
    @(negedge clk); op = 4'd3; start = 1'b1; opr1 = 32'd1000; opr2 = 32'd3;
    @(posedge clk); #1;
    @(negedge clk); start = 1'b0;
    seen = 1'b0;
    repeat (4) begin @(posedge clk); #1; if (done) seen = 1'b1; end
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1;
    if (done) seen = 1'b1;
    check("flush_busy", 64'(busy), 64'h0);
    check("flush_no_done", 64'(seen), 64'h0);
    check("flush_hold", {hi_o, lo_o}, last_res);
    flush = 1'b0;
    do_op(4'd2, 32'd3, 32'd4, 32'h0, 32'h0, "after_flush");

    // reset in the middle of a DIV
    @(negedge clk); op = 4'd3; start = 1'b1; opr1 = 32'd77; opr2 = 32'd5;
    @(posedge clk); #1;
    @(negedge clk); start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    #1;
    check("midrst_outputs", {62'h0, busy, done}, 64'h0);
    check("midrst_result", {hi_o, lo_o}, 64'h0);
    @(negedge clk); rst = 1'b0;
    last_res = '0;
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (done || busy) seen = 1'b1; end
    check("midrst_no_done", 64'(seen), 64'h0);

    // randomized ops with corner operands mixed in
    for (int i = 0; i < 60; i++) begin
      o = 4'($urandom_range(0, 9));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'h0;
        1: b = 32'h8000_0000;
        2: b = 32'hFFFF_FFFF;
        3: b = 32'($urandom_range(1, 15));
        default: ;
      endcase
      case ($urandom_range(0, 7))
        0: a = 32'h8000_0000;
        1: a = 32'hFFFF_FFFF;
        2: a = 32'h0;
        default: ;
      endcase
      do_op(o, a, b, $urandom, $urandom, $sformatf("rand%0d_op%0d", i, o));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
